conv3x3_engine: RTL and testbench

Parametrised successor to the fixed 3x3 box-blur convolver. It holds a runtime-loadable signed 3x3 kernel (shadow and active banks), takes a programmable normalisation shift, and clamps results to pixel range. It has a valid/ready handshake on both sides and a saturation counter. It sits between the line-buffer window generator and the output DMA/stream stage.

---
 rtl/conv3x3_engine.sv | 176 +++++++++++++++++
 tb/tb_conv3x3_engine.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_engine.sv
// conv3x3_engine: 3x3 signed-kernel convolver with shadow/active kernel banks,
// programmable normalisation shift and clamp to pixel range.
//
// Pipeline: S1 multiply -> S2 adder tree -> S3 shift/clamp into output register.
// A single enable stalls every stage while the output is held for downstream.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_pixel_data[_valid]    3x3 window in (tap k at [k*DATA_W +: DATA_W])
//   o_pixel_ready           window accepted this cycle when valid
//   o_convolved_data[_valid], i_convolved_ready   result stream out
//   i_coef_wr/addr/data     shadow kernel write (addr 9..15 ignored)
//   i_coef_commit           copy shadow bank (including same-cycle write) to active
//   i_shift                 arithmetic right shift applied in S3
//   o_sat_count             saturating count of clamped results
//
// Optional build macro CONV3X3_ABS_EN: S3 takes |x| of the shifted sum before
// clamping (edge-magnitude mode), so only the upper clamp can saturate.

module conv3x3_engine #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned COEF_W  = 8,
  parameter int unsigned SHIFT_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [9*DATA_W-1:0]      i_pixel_data,
  input  logic                     i_pixel_data_valid,
  output logic                     o_pixel_ready,
  output logic [DATA_W-1:0]        o_convolved_data,
  output logic                     o_convolved_data_valid,
  input  logic                     i_convolved_ready,
  input  logic                     i_coef_wr,
  input  logic [3:0]               i_coef_addr,
  input  logic signed [COEF_W-1:0] i_coef_data,
  input  logic                     i_coef_commit,
  input  logic [SHIFT_W-1:0]       i_shift,
  output logic [CNT_W-1:0]         o_sat_count
);

  localparam int unsigned ProdW = DATA_W + COEF_W + 1;
  localparam int unsigned AccW  = ProdW + 4;
  localparam logic signed [AccW-1:0] PixMax = {{(AccW - DATA_W){1'b0}}, {DATA_W{1'b1}}};

  // Kernel banks
  logic signed [COEF_W-1:0] shadow_q [9];
  logic signed [COEF_W-1:0] shadow_d [9];
  logic signed [COEF_W-1:0] active_q [9];
  logic signed [COEF_W-1:0] active_d [9];

  // Pipeline state
  logic signed [ProdW-1:0] pix_ext  [9];
  logic signed [ProdW-1:0] coef_ext [9];
  logic signed [ProdW-1:0] prod_q   [9];
  logic signed [ProdW-1:0] prod_d   [9];
  logic                    s1_valid_q, s1_valid_d;
  logic signed [AccW-1:0]  prod_acc [9];
  logic signed [AccW-1:0]  sum_tree;
  logic signed [AccW-1:0]  sum_q, sum_d;
  logic                    s2_valid_q, s2_valid_d;
  logic signed [AccW-1:0]  shifted;
  logic [DATA_W-1:0]       clamp_res;
  logic                    clamp_sat;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic [CNT_W-1:0]        sat_cnt_q, sat_cnt_d;
  logic                    en;

  // Whole pipeline advances unless a valid result is being held for downstream.
  assign en            = !(out_valid_q && !i_convolved_ready);
  assign o_pixel_ready = en;

  // Kernel update: write lands in shadow first so a same-cycle commit sees it.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      shadow_d[k] = shadow_q[k];
      if (i_coef_wr && (i_coef_addr == 4'(k))) begin
        shadow_d[k] = i_coef_data;
      end
      active_d[k] = i_coef_commit ? shadow_d[k] : active_q[k];
    end
  end

  // S1: pixels zero-extended to signed, multiplied by active coefficients
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      pix_ext[k]  = {{(ProdW - DATA_W){1'b0}}, i_pixel_data[k*DATA_W +: DATA_W]};
      coef_ext[k] = {{(ProdW - COEF_W){active_q[k][COEF_W-1]}}, active_q[k]};
      prod_d[k]   = en ? (pix_ext[k] * coef_ext[k]) : prod_q[k];
    end
    s1_valid_d = en ? i_pixel_data_valid : s1_valid_q;
  end

  // S2: adder tree over sign-extended products; AccW leaves headroom for 9 terms
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_acc[k] = {{(AccW - ProdW){prod_q[k][ProdW-1]}}, prod_q[k]};
    end
    sum_tree = ((prod_acc[0] + prod_acc[1]) + (prod_acc[2] + prod_acc[3]))
             + ((prod_acc[4] + prod_acc[5]) + (prod_acc[6] + prod_acc[7]))
             + prod_acc[8];
    sum_d      = en ? sum_tree : sum_q;
    s2_valid_d = en ? s1_valid_q : s2_valid_q;
  end

  // S3: normalise and clamp
`ifdef CONV3X3_ABS_EN
  logic signed [AccW-1:0] mag;
  always_comb begin
    shifted   = sum_q >>> i_shift;
    mag       = shifted[AccW-1] ? -shifted : shifted;
    clamp_sat = (mag > PixMax);
    clamp_res = clamp_sat ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
  end
`else
  always_comb begin
    shifted   = sum_q >>> i_shift;
    clamp_sat = 1'b0;
    clamp_res = shifted[DATA_W-1:0];
    if (shifted[AccW-1]) begin
      clamp_sat = 1'b1;
      clamp_res = '0;
    end else if (shifted > PixMax) begin
      clamp_sat = 1'b1;
      clamp_res = {DATA_W{1'b1}};
    end
  end
`endif

  always_comb begin
    out_valid_d = en ? s2_valid_q : out_valid_q;
    out_data_d  = out_data_q;
    sat_cnt_d   = sat_cnt_q;
    if (en && s2_valid_q) begin
      out_data_d = clamp_res;
      // Counter sticks at all-ones rather than wrapping
      if (clamp_sat && (sat_cnt_q != {CNT_W{1'b1}})) begin
        sat_cnt_d = sat_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 9; k++) begin
        shadow_q[k] <= COEF_W'(k == 4);
        active_q[k] <= COEF_W'(k == 4);
        prod_q[k]   <= '0;
      end
      s1_valid_q  <= 1'b0;
      sum_q       <= '0;
      s2_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      for (int k = 0; k < 9; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
        prod_q[k]   <= prod_d[k];
      end
      s1_valid_q  <= s1_valid_d;
      sum_q       <= sum_d;
      s2_valid_q  <= s2_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign o_convolved_data       = out_data_q;
  assign o_convolved_data_valid = out_valid_q;
  assign o_sat_count            = sat_cnt_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Testbench for conv3x3_engine: randomized and directed windows, scoreboard
// queue filled at accept time from an integer reference model, monitor process
// pops and compares on every output handshake.

module tb_conv3x3_engine;

  localparam int DATA_W  = 8;
  localparam int COEF_W  = 8;
  localparam int SHIFT_W = 4;
  localparam int CNT_W   = 16;
  localparam int WIN_W   = 9 * DATA_W;
  localparam int PIX_MAX = (1 << DATA_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                     i_clk;
  logic                     i_rst;
  logic [WIN_W-1:0]         i_pixel_data;
  logic                     i_pixel_data_valid;
  logic                     o_pixel_ready;
  logic [DATA_W-1:0]        o_convolved_data;
  logic                     o_convolved_data_valid;
  logic                     i_convolved_ready;
  logic                     i_coef_wr;
  logic [3:0]               i_coef_addr;
  logic signed [COEF_W-1:0] i_coef_data;
  logic                     i_coef_commit;
  logic [SHIFT_W-1:0]       i_shift;
  logic [CNT_W-1:0]         o_sat_count;

  conv3x3_engine #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .SHIFT_W(SHIFT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk                 (i_clk),
    .i_rst                 (i_rst),
    .i_pixel_data          (i_pixel_data),
    .i_pixel_data_valid    (i_pixel_data_valid),
    .o_pixel_ready         (o_pixel_ready),
    .o_convolved_data      (o_convolved_data),
    .o_convolved_data_valid(o_convolved_data_valid),
    .i_convolved_ready     (i_convolved_ready),
    .i_coef_wr             (i_coef_wr),
    .i_coef_addr           (i_coef_addr),
    .i_coef_data           (i_coef_data),
    .i_coef_commit         (i_coef_commit),
    .i_shift               (i_shift),
    .o_sat_count           (o_sat_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_val_q[$];
  bit exp_sat_q[$];
  int exp_sat  = 0;
  int pops     = 0;
  int cur_shift = 0;
  int kshadow[9];
  int kactive[9];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference: integer dot product, arithmetic shift, clamp to pixel range
  task automatic ref_model(input logic [WIN_W-1:0] win, output int val, output bit sat);
    int sum;
    int sh;
    sum = 0;
    for (int k = 0; k < 9; k++) sum += int'(win[k*DATA_W +: DATA_W]) * kactive[k];
    sh = sum >>> cur_shift;
`ifdef CONV3X3_ABS_EN
    if (sh < 0) sh = -sh;
`endif
    if (sh < 0) begin
      val = 0; sat = 1'b1;
    end else if (sh > PIX_MAX) begin
      val = PIX_MAX; sat = 1'b1;
    end else begin
      val = sh; sat = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 9; k++) begin
      kshadow[k] = (k == 4) ? 1 : 0;
      kactive[k] = kshadow[k];
    end
    exp_val_q.delete();
    exp_sat_q.delete();
    exp_sat = 0;
  endtask

  // One clock cycle of stimulus; accept decision is taken before the active edge
  task automatic step(input bit v, input logic [WIN_W-1:0] win, input bit r, input bit wr,
                      input logic [3:0] addr, input int cd, input bit cm, output bit acc);
    int val;
    bit sat;
    @(posedge i_clk);
    #1;
    i_pixel_data_valid = v;
    i_pixel_data       = win;
    i_convolved_ready  = r;
    i_coef_wr          = wr;
    i_coef_addr        = addr;
    i_coef_data        = COEF_W'(cd);
    i_coef_commit      = cm;
    @(negedge i_clk);
    acc = v && o_pixel_ready;
    if (acc) begin
      ref_model(win, val, sat);
      exp_val_q.push_back(val);
      exp_sat_q.push_back(sat);
    end
    if (wr && addr <= 4'd8) kshadow[addr] = cd;
    if (cm) for (int k = 0; k < 9; k++) kactive[k] = kshadow[k];
  endtask

  task automatic idle(input bit r);
    bit acc;
    step(1'b0, '0, r, 1'b0, 4'd0, 0, 1'b0, acc);
  endtask

  task automatic send(input logic [WIN_W-1:0] win);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, win, 1'b1, 1'b0, 4'd0, 0, 1'b0, acc);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_val_q.size() > 0; i++) idle(1'b1);
    check("drain_empty", exp_val_q.size(), 0);
  endtask

  // All nine writes, commit issued together with the last write
  task automatic load_kernel(input int k[9]);
    bit acc;
    for (int i = 0; i < 9; i++)
      step(1'b0, '0, 1'b1, 1'b1, 4'(i), k[i], (i == 8), acc);
  endtask

  function automatic logic [WIN_W-1:0] mk_win(input int centre, input int other);
    logic [WIN_W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*DATA_W +: DATA_W] = DATA_W'((k == 4) ? centre : other);
    return w;
  endfunction

  function automatic logic [WIN_W-1:0] rand_win();
    logic [WIN_W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    return w;
  endfunction

  // Monitor: scoreboard pop on handshake, plus hold-stability while stalled
  bit                held_v = 1'b0;
  logic [DATA_W-1:0] held_d = '0;
  initial begin
    int ev;
    bit es;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v)
          check("hold_stable", o_convolved_data_valid ? int'(o_convolved_data) : -1,
                int'(held_d));
        if (o_convolved_data_valid && i_convolved_ready) begin
          if (exp_val_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got %0d, expected no output", o_convolved_data);
          end else begin
            ev = exp_val_q.pop_front();
            es = exp_sat_q.pop_front();
            if (es && exp_sat < CNT_MAX) exp_sat++;
            check("out_data", int'(o_convolved_data), ev);
            check("sat_count", int'(o_sat_count), exp_sat);
            pops++;
          end
        end
        held_v = o_convolved_data_valid && !i_convolved_ready;
        held_d = o_convolved_data;
      end
    end
  end

  initial begin
    bit acc;
    int kern[9];
    int p0;
    int sent;
    int stall;
    bit seen;
    bit v;
    bit r;
    logic [WIN_W-1:0] win;

    i_rst = 1'b1;
    i_pixel_data = '0;
    i_pixel_data_valid = 1'b0;
    i_convolved_ready = 1'b0;
    i_coef_wr = 1'b0;
    i_coef_addr = '0;
    i_coef_data = '0;
    i_coef_commit = 1'b0;
    i_shift = '0;
    model_reset();
    repeat (3) @(negedge i_clk);
    check("rst_valid", int'(o_convolved_data_valid), 0);
    check("rst_data", int'(o_convolved_data), 0);
    check("rst_sat", int'(o_sat_count), 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_ready", int'(o_pixel_ready), 1);

    // Identity kernel, latency of exactly three cycles
    send(mk_win(8'h5A, 8'hFF));
    idle(1'b1); check("lat_c1", int'(o_convolved_data_valid), 0);
    idle(1'b1); check("lat_c2", int'(o_convolved_data_valid), 0);
    idle(1'b1); check("lat_c3", int'(o_convolved_data_valid), 1);
    check("lat_c3_data", int'(o_convolved_data), 'h5A);
    drain();
    check("identity_sat", int'(o_sat_count), 0);

    // Box kernel, shift 3
    kern = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    load_kernel(kern);
    cur_shift = 3; i_shift = SHIFT_W'(cur_shift);
    send(mk_win(255, 255));
    send(mk_win(16, 16));
    drain();
    check("box_sat", int'(o_sat_count), 1);

    // Laplacian, shift 0
    kern = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    load_kernel(kern);
    cur_shift = 0; i_shift = '0;
    send(mk_win(100, 100));
    send(mk_win(120, 100));
    send(mk_win(80, 100));
    drain();
`ifdef CONV3X3_ABS_EN
    check("lap_sat", int'(o_sat_count), 1);
`else
    check("lap_sat", int'(o_sat_count), 2);
`endif

    // Six back-to-back windows, ready dropped four cycles after first output
    for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 255)) - 128;
    load_kernel(kern);
    cur_shift = 4; i_shift = SHIFT_W'(cur_shift);
    p0 = pops; sent = 0; stall = 0; seen = 1'b0;
    win = rand_win();
    for (int cyc = 0; cyc < 60 && (sent < 6 || exp_val_q.size() > 0); cyc++) begin
      step(sent < 6, win, (stall == 0), 1'b0, 4'd0, 0, 1'b0, acc);
      if (acc) begin sent++; win = rand_win(); end
      if (stall > 0) begin
        check("stall_ready_low", int'(o_pixel_ready), 0);
        stall--;
      end else if (!seen && o_convolved_data_valid) begin
        seen = 1'b1;
        stall = 4;
      end
    end
    check("stall_delivered", pops - p0, 6);

    // Write to addr 9 then commit: kernel unchanged
    step(1'b0, '0, 1'b1, 1'b1, 4'd9, 77, 1'b1, acc);
    for (int i = 0; i < 3; i++) send(rand_win());
    // Shadow-only write to tap 4: outputs unchanged
    step(1'b0, '0, 1'b1, 1'b1, 4'd4, 50, 1'b0, acc);
    for (int i = 0; i < 3; i++) send(rand_win());
    drain();

    // Commit mid-stream: new kernel staged in shadow, committed alongside a window
    for (int i = 0; i < 9; i++) begin
      step(1'b0, '0, 1'b1, 1'b1, 4'(i), int'($urandom_range(0, 255)) - 128, 1'b0, acc);
    end
    for (int i = 0; i < 10; i++) begin
      win = rand_win();
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++)
        step(1'b1, win, 1'b1, 1'b0, 4'd0, 0, (i == 5 && t == 0), acc);
    end
    drain();

    // Randomized batches
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(0, 255)) - 128;
      load_kernel(kern);
      cur_shift = int'($urandom_range(0, 15)); i_shift = SHIFT_W'(cur_shift);
      sent = 0; v = 1'b0; win = rand_win();
      for (int cyc = 0; cyc < 400 && sent < 25; cyc++) begin
        if (!v) v = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 7);
        step(v, win, r, 1'b0, 4'd0, 0, 1'b0, acc);
        if (acc) begin sent++; v = 1'b0; win = rand_win(); end
      end
      check("rand_sent", sent, 25);
      drain();
    end

    // Asynchronous reset with windows in flight and an output held
    for (int i = 0; i < 3; i++) send(rand_win());
    repeat (3) idle(1'b0);
    check("pre_rst_valid", int'(o_convolved_data_valid), 1);
    #3;
    i_rst = 1'b1;
    #1;
    check("async_rst_valid", int'(o_convolved_data_valid), 0);
    check("async_rst_data", int'(o_convolved_data), 0);
    check("async_rst_sat", int'(o_sat_count), 0);
    model_reset();
    cur_shift = 0; i_shift = '0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    p0 = pops;
    send(mk_win(8'h33, 8'hC0));
    repeat (10) idle(1'b1);
    check("post_rst_outputs", pops - p0, 1);
    check("post_rst_sat", int'(o_sat_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
